// File: rtl/rv32i_decode_pkg.sv
// Shared RV32I decode types: opcode values, ALU funct3 codes, op classes and the decoded record.
// DECODE_ILLEGAL_TRAP_EN adds the illegal flag to the decoded record.
package rv32i_decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct3 encodings understood by the ALU
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_ALU_IMM = 4'd7,
        CLS_ALU_REG = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd11
    } op_class_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alu_alt;
        logic        use_imm;
        logic [31:0] immediate;
        op_class_t   op_class;
        logic [31:0] pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } decoded_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate extraction; format chosen by op class, sign-extended from instr[31].
module rv32i_imm_gen
    import rv32i_decode_pkg::*;
(
    input  logic [31:7] instr,
    input  op_class_t   op_class,
    output logic [31:0] immediate
);

    always_comb begin
        immediate = '0;
        case (op_class)
            CLS_JALR, CLS_LOAD, CLS_ALU_IMM, CLS_FENCE, CLS_SYSTEM:
                immediate = {{20{instr[31]}}, instr[31:20]};
            CLS_STORE:
                immediate = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            CLS_BRANCH:
                immediate = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                immediate = {instr[31:12], 12'b0};
            CLS_JAL:
                immediate = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                immediate = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage with a 2-entry skid buffer and registered fetch_ready.
// DECODE_ILLEGAL_TRAP_EN: adds the illegal port and funct7 checks; otherwise illegal words become NOP.
module rv32i_decode_stage
    import rv32i_decode_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [31:0]     fetch_instruction,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            decode_valid,
    input  logic            decode_ready,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic            alu_alt,
    output logic            use_imm,
    output logic [XLEN-1:0] immediate,
    output op_class_t       op_class,
    output logic [XLEN-1:0] pc_out,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic            illegal,
`endif
    output buf_state_t      buffer_state
);

    // Handshake: a word moves on a rising edge when valid && ready; the producer holds valid
    // and data until then, and the decoded record stays stable while decode_valid && !decode_ready.

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  f3;
    op_class_t   cls;
    logic [31:0] imm;
    decoded_t    dec;

    assign opcode = fetch_instruction[6:0];
    assign funct7 = fetch_instruction[31:25];
    assign f3     = fetch_instruction[14:12];

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_LUI:      cls = CLS_LUI;
            OPC_AUIPC:    cls = CLS_AUIPC;
            OPC_JAL:      cls = CLS_JAL;
            OPC_JALR:     cls = CLS_JALR;
            OPC_BRANCH:   cls = CLS_BRANCH;
            OPC_LOAD:     cls = CLS_LOAD;
            OPC_STORE:    cls = CLS_STORE;
            OPC_OP_IMM:   cls = CLS_ALU_IMM;
            OPC_OP:       cls = CLS_ALU_REG;
            OPC_MISC_MEM: cls = CLS_FENCE;
            OPC_SYSTEM:   cls = CLS_SYSTEM;
            default:      cls = CLS_ILLEGAL;
        endcase
        if (fetch_instruction[1:0] != 2'b11) cls = CLS_ILLEGAL;
`ifdef DECODE_ILLEGAL_TRAP_EN
        // funct7 0x20 is only meaningful as SUB/SRA (and SRAI for shift immediates)
        if (cls == CLS_ALU_REG && !(funct7 == 7'h00 || (funct7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SRL))))
            cls = CLS_ILLEGAL;
        if (cls == CLS_ALU_IMM && f3 == F3_SLL && funct7 != 7'h00)
            cls = CLS_ILLEGAL;
        if (cls == CLS_ALU_IMM && f3 == F3_SRL && funct7 != 7'h00 && funct7 != 7'h20)
            cls = CLS_ILLEGAL;
`endif
    end

    rv32i_imm_gen u_imm_gen (
        .instr     (fetch_instruction[31:7]),
        .op_class  (cls),
        .immediate (imm)
    );

    always_comb begin
        dec           = '0;
        dec.rd        = (cls == CLS_STORE || cls == CLS_BRANCH) ? 5'd0 : fetch_instruction[11:7];
        dec.rs1       = fetch_instruction[19:15];
        dec.rs2       = fetch_instruction[24:20];
        dec.funct3    = f3;
        dec.alu_alt   = fetch_instruction[30] &&
                        (cls == CLS_ALU_REG || (cls == CLS_ALU_IMM && f3 == F3_SRL));
        dec.use_imm   = cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
                                    CLS_LOAD, CLS_STORE, CLS_ALU_IMM};
        dec.immediate = imm;
        dec.op_class  = cls;
        dec.pc        = fetch_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal   = (cls == CLS_ILLEGAL);
`else
        // Unrecognised words are issued as ADDI x0,x0,0 so downstream never sees ILLEGAL
        if (cls == CLS_ILLEGAL) begin
            dec          = '0;
            dec.op_class = CLS_ALU_IMM;
            dec.use_imm  = 1'b1;
            dec.pc       = fetch_pc;
        end
`endif
    end

    buf_state_t state, next_state;
    decoded_t   slot0, slot1;
    logic       ready_q;
    logic       accept;
    logic       drain;

    assign accept = fetch_valid && ready_q;
    assign drain  = (state != BUF_EMPTY) && decode_ready;

    always_comb begin
        next_state = state;
        case (state)
            BUF_EMPTY: if (accept)          next_state = BUF_ONE;
            BUF_ONE: begin
                if (accept && !drain)       next_state = BUF_FULL;
                else if (drain && !accept)  next_state = BUF_EMPTY;
            end
            BUF_FULL:  if (drain)           next_state = BUF_ONE;
            default:                        next_state = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= BUF_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != BUF_FULL);
        end
    end

    // slot0 always holds the oldest record; slot1 catches the word in flight when stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case (state)
                BUF_EMPTY: if (accept) slot0 <= dec;
                BUF_ONE: begin
                    if (accept && drain) slot0 <= dec;
                    else if (accept)     slot1 <= dec;
                end
                BUF_FULL:  if (drain)  slot0 <= slot1;
                default: ;
            endcase
        end
    end

    assign fetch_ready  = ready_q;
    assign decode_valid = (state != BUF_EMPTY);
    assign rd           = slot0.rd;
    assign rs1          = slot0.rs1;
    assign rs2          = slot0.rs2;
    assign funct3       = slot0.funct3;
    assign alu_alt      = slot0.alu_alt;
    assign use_imm      = slot0.use_imm;
    assign immediate    = slot0.immediate;
    assign op_class     = slot0.op_class;
    assign pc_out       = decode_valid ? slot0.pc : RESET_PC;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal      = slot0.illegal;
`endif
    assign buffer_state = state;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed decodes, stall/skid, reset flush and randomized traffic.
module tb_rv32i_decode_stage;
    import rv32i_decode_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clock;
    logic        reset_n;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic        decode_valid;
    logic        decode_ready;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        alu_alt, use_imm;
    logic [31:0] immediate;
    op_class_t   op_class;
    logic [31:0] pc_out;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    buf_state_t  buffer_state;

    rv32i_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_instruction (fetch_instruction),
        .fetch_pc          (fetch_pc),
        .decode_valid      (decode_valid),
        .decode_ready      (decode_ready),
        .rd                (rd),
        .rs1               (rs1),
        .rs2               (rs2),
        .funct3            (funct3),
        .alu_alt           (alu_alt),
        .use_imm           (use_imm),
        .immediate         (immediate),
        .op_class          (op_class),
        .pc_out            (pc_out),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal           (illegal),
`endif
        .buffer_state      (buffer_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int       n_cmp = 0;
    int       n_err = 0;
    decoded_t exp_q[$];
    logic     hold_valid = 1'b0;
    decoded_t hold_rec;
    logic     last_accept = 1'b0;

    logic [6:0] opc_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference decoder built from the ISA field rules with integer arithmetic
    function automatic decoded_t model(input logic [31:0] w, input logic [31:0] pc);
        decoded_t  e;
        op_class_t c;
        int        s, f3, f7, imm;
        s  = signed'(w);
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        case (w[6:0])
            7'h37: c = CLS_LUI;
            7'h17: c = CLS_AUIPC;
            7'h6F: c = CLS_JAL;
            7'h67: c = CLS_JALR;
            7'h63: c = CLS_BRANCH;
            7'h03: c = CLS_LOAD;
            7'h23: c = CLS_STORE;
            7'h13: c = CLS_ALU_IMM;
            7'h33: c = CLS_ALU_REG;
            7'h0F: c = CLS_FENCE;
            7'h73: c = CLS_SYSTEM;
            default: c = CLS_ILLEGAL;
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (c == CLS_ALU_REG && !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)))) c = CLS_ILLEGAL;
        if (c == CLS_ALU_IMM && f3 == 1 && f7 != 0) c = CLS_ILLEGAL;
        if (c == CLS_ALU_IMM && f3 == 5 && f7 != 0 && f7 != 32) c = CLS_ILLEGAL;
`endif
        e    = '0;
        e.pc = pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.illegal = (c == CLS_ILLEGAL);
`else
        if (c == CLS_ILLEGAL) begin
            e.op_class = CLS_ALU_IMM;
            e.use_imm  = 1'b1;
            return e;
        end
`endif
        e.op_class = c;
        e.rd       = (c == CLS_STORE || c == CLS_BRANCH) ? 5'd0 : 5'((w >> 7) & 31);
        e.rs1      = 5'((w >> 15) & 31);
        e.rs2      = 5'((w >> 20) & 31);
        e.funct3   = 3'(f3);
        e.alu_alt  = (c == CLS_ALU_REG || (c == CLS_ALU_IMM && f3 == 5)) ? w[30] : 1'b0;
        e.use_imm  = (c == CLS_LUI || c == CLS_AUIPC || c == CLS_JAL || c == CLS_JALR ||
                      c == CLS_LOAD || c == CLS_STORE || c == CLS_ALU_IMM);
        case (c)
            CLS_JALR, CLS_LOAD, CLS_ALU_IMM, CLS_FENCE, CLS_SYSTEM:
                imm = s >>> 20;
            CLS_STORE:
                imm = (s >>> 25) * 32 + int'((w >> 7) & 31);
            CLS_BRANCH:
                imm = (s >>> 31) * 4096 + int'(w[7]) * 2048 + int'((w >> 25) & 63) * 32
                      + int'((w >> 8) & 15) * 2;
            CLS_LUI, CLS_AUIPC:
                imm = int'(w & 32'hFFFF_F000);
            CLS_JAL:
                imm = (s >>> 31) * 1048576 + int'((w >> 12) & 255) * 4096 + int'(w[20]) * 2048
                      + int'((w >> 21) & 1023) * 2;
            default:
                imm = 0;
        endcase
        e.immediate = 32'(imm);
        return e;
    endfunction

    function automatic decoded_t observe();
        decoded_t o;
        o           = '0;
        o.rd        = rd;
        o.rs1       = rs1;
        o.rs2       = rs2;
        o.funct3    = funct3;
        o.alu_alt   = alu_alt;
        o.use_imm   = use_imm;
        o.immediate = immediate;
        o.op_class  = op_class;
        o.pc        = pc_out;
`ifdef DECODE_ILLEGAL_TRAP_EN
        o.illegal   = illegal;
`endif
        return o;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 12);
        if (r < 11) w[6:0] = opc_tab[r];
        if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    // driver + scoreboard: called at a falling edge, resolves the coming rising edge
    task automatic step(input logic fv, input logic [31:0] w, input logic [31:0] pc, input logic dr);
        decoded_t o;
        o = observe();
        if (hold_valid) check("hold_stable", o, hold_rec);
        fetch_valid       = fv;
        fetch_instruction = w;
        fetch_pc          = pc;
        decode_ready      = dr;
        if (decode_valid && decode_ready) begin
            if (exp_q.size() == 0) check("spurious_valid", decode_valid, 1'b0);
            else                   check("record", o, exp_q.pop_front());
        end
        last_accept = fetch_valid && fetch_ready;
        if (last_accept) exp_q.push_back(model(w, pc));
        hold_valid = decode_valid && !decode_ready;
        hold_rec   = o;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] w, pc;
        logic        pend;
        int          n_acc;

        reset_n = 1'b0; fetch_valid = 1'b0; fetch_instruction = '0; fetch_pc = '0; decode_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_decode_valid", decode_valid, 1'b0);
        check("rst_fetch_ready", fetch_ready, 1'b0);
        check("rst_pc_out", pc_out, RST_PC);
        check("rst_rd", rd, 5'd0);
        check("rst_immediate", immediate, 32'd0);
        check("rst_op_class", op_class, 4'd0);
        check("rst_state", buffer_state, BUF_EMPTY);
        reset_n = 1'b1;
        check("ready_before_edge", fetch_ready, 1'b0);
        @(posedge clock);
        @(negedge clock);
        check("ready_after_edge", fetch_ready, 1'b1);

        // directed decodes, one cycle latency each
        step(1'b1, 32'h0050_0093, 32'h0000_1000, 1'b1);
        check("addi_valid", decode_valid, 1'b1);
        check("addi_rd", rd, 5'd1);
        check("addi_rs1", rs1, 5'd0);
        check("addi_funct3", funct3, 3'd0);
        check("addi_use_imm", use_imm, 1'b1);
        check("addi_imm", immediate, 32'd5);
        check("addi_class", op_class, CLS_ALU_IMM);
        check("addi_pc", pc_out, 32'h0000_1000);
        step(1'b1, 32'h4020_81B3, 32'h0000_1004, 1'b1);
        check("sub_rd", rd, 5'd3);
        check("sub_rs1", rs1, 5'd1);
        check("sub_rs2", rs2, 5'd2);
        check("sub_alt", alu_alt, 1'b1);
        check("sub_use_imm", use_imm, 1'b0);
        check("sub_class", op_class, CLS_ALU_REG);
        step(1'b1, 32'hFE00_0EE3, 32'h0000_1008, 1'b1);
        check("beq_imm", immediate, 32'hFFFF_FFFC);
        check("beq_rd", rd, 5'd0);
        check("beq_class", op_class, CLS_BRANCH);
        step(1'b1, 32'h1234_5037, 32'h0000_100C, 1'b1);
        check("lui_imm", immediate, 32'h1234_5000);
        check("lui_class", op_class, CLS_LUI);
        step(1'b1, 32'h0000_0000, 32'h0000_1010, 1'b1);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("zero_illegal", illegal, 1'b1);
        check("zero_class", op_class, CLS_ILLEGAL);
`else
        check("zero_rd", rd, 5'd0);
        check("zero_imm", immediate, 32'd0);
        check("zero_use_imm", use_imm, 1'b1);
        check("zero_class", op_class, CLS_ALU_IMM);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b1);
        check("idle_valid", decode_valid, 1'b0);
        check("idle_pc", pc_out, RST_PC);

        // stalled consumer: three offers, two absorbed
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rand_instr(), 32'h0000_2000 + 32'(i * 4), 1'b0);
            if (last_accept) n_acc++;
        end
        check("stall_accepts", n_acc, 2);
        check("stall_fetch_ready", fetch_ready, 1'b0);
        check("stall_state", buffer_state, BUF_FULL);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
        check("stall_drained", exp_q.size(), 0);
        check("stall_idle_valid", decode_valid, 1'b0);

        // reset while full
        step(1'b1, rand_instr(), 32'h0000_3000, 1'b0);
        step(1'b1, rand_instr(), 32'h0000_3004, 1'b0);
        check("pre_reset_state", buffer_state, BUF_FULL);
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", decode_valid, 1'b0);
        check("async_reset_ready", fetch_ready, 1'b0);
        check("async_reset_pc", pc_out, RST_PC);
        exp_q.delete();
        hold_valid = 1'b0;
        fetch_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1);
            check("post_reset_no_stale", decode_valid, 1'b0);
        end
        check("post_reset_ready", fetch_ready, 1'b1);

        // randomized traffic with random back-pressure
        pend = 1'b0;
        w    = '0;
        pc   = '0;
        for (int i = 0; i < 800; i++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                w    = rand_instr();
                pc   = $urandom & 32'hFFFF_FFFC;
                pend = 1'b1;
            end
            step(pend, w, pc, $urandom_range(0, 3) != 0);
            if (last_accept) pend = 1'b0;
        end
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
        check("final_drain", exp_q.size(), 0);
        check("final_valid", decode_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
